// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with a valid/ready handshake,
// a one-entry skid buffer and a synchronous flush.
//
// Optional feature: define IF_ID_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of cycles in which decode held a valid entry back.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side. IF_ready is registered and depends only on the
// stage's own occupancy, never on IF_valid. ID_valid/ID_* hold stable while
// ID_ready is 0 until the entry is consumed or flushed.
module if_id_skid_reg #(
   parameter int unsigned      INS_W   = 32,
   parameter int unsigned      PC_W    = 32,
   parameter logic [INS_W-1:0] NOP_INS = '0,
   parameter int unsigned      CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IF_valid,
   output logic             IF_ready,
   input  logic [PC_W-1:0]  IF_pc_plus_4,
   input  logic [INS_W-1:0] IF_ins,
   output logic             ID_valid,
   input  logic             ID_ready,
   output logic [PC_W-1:0]  ID_pc_plus_4,
   output logic [INS_W-1:0] ID_ins,
   input  logic             flush
`ifdef IF_ID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   // State encoding doubles as the valid bits: bit 0 = main valid,
   // bit 1 = skid valid. 2'b10 cannot occur and recovers to EMPTY.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_e;

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("if_id_skid_reg: CNT_W must be at least 1");
   end

   state_e           state_q,    state_d;
   logic             if_ready_q, if_ready_d;
   logic [PC_W-1:0]  main_pc_q,  main_pc_d;
   logic [INS_W-1:0] main_ins_q, main_ins_d;
   logic [PC_W-1:0]  skid_pc_q,  skid_pc_d;
   logic [INS_W-1:0] skid_ins_q, skid_ins_d;

   logic main_valid;
   logic if_xfer;
   logic id_xfer;

   assign main_valid = state_q[0];
   assign if_xfer    = IF_valid & if_ready_q;
   assign id_xfer    = main_valid & ID_ready;

   // Next-state and data-path selection; flush overrides everything and
   // drops any word fetch presents in the same cycle.
   always_comb begin
      state_d    = state_q;
      main_pc_d  = main_pc_q;
      main_ins_d = main_ins_q;
      skid_pc_d  = skid_pc_q;
      skid_ins_d = skid_ins_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (if_xfer) begin
                  main_pc_d  = IF_pc_plus_4;
                  main_ins_d = IF_ins;
                  state_d    = ST_ONE;
               end
            end
            ST_ONE: begin
               if (if_xfer && id_xfer) begin
                  main_pc_d  = IF_pc_plus_4;
                  main_ins_d = IF_ins;
               end else if (if_xfer) begin
                  skid_pc_d  = IF_pc_plus_4;
                  skid_ins_d = IF_ins;
                  state_d    = ST_FULL;
               end else if (id_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // IF_ready is 0 here, so only the drain path can fire.
               if (id_xfer) begin
                  main_pc_d  = skid_pc_q;
                  main_ins_d = skid_ins_q;
                  state_d    = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      if_ready_d = (state_d != ST_FULL);
   end

   // State, registered ready and held entries; reset empties the stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         if_ready_q <= 1'b1;
         main_pc_q  <= '0;
         main_ins_q <= '0;
         skid_pc_q  <= '0;
         skid_ins_q <= '0;
      end else begin
         state_q    <= state_d;
         if_ready_q <= if_ready_d;
         main_pc_q  <= main_pc_d;
         main_ins_q <= main_ins_d;
         skid_pc_q  <= skid_pc_d;
         skid_ins_q <= skid_ins_d;
      end
   end

   assign IF_ready     = if_ready_q;
   assign ID_valid     = main_valid;
   assign ID_pc_plus_4 = main_valid ? main_pc_q  : '0;
   assign ID_ins       = main_valid ? main_ins_q : NOP_INS;

`ifdef IF_ID_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Count edges where decode holds a valid entry back, saturating at max.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid && !ID_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall counter register; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: directed scenarios plus a randomised run for
// if_id_skid_reg, with a FIFO scoreboard tracking entries in flight.
`timescale 1ns/1ps
module tb_if_id_skid_reg;

   localparam int unsigned      INS_W = 32;
   localparam int unsigned      PC_W  = 32;
   localparam logic [INS_W-1:0] NOP   = 32'h0000_0013;
`ifdef IF_ID_STALL_CNT_EN
   localparam int unsigned      CNT_W = 4;
`else
   localparam int unsigned      CNT_W = 32;
`endif

   logic             clk;
   logic             rst_n;
   logic             IF_valid;
   logic             IF_ready;
   logic [PC_W-1:0]  IF_pc_plus_4;
   logic [INS_W-1:0] IF_ins;
   logic             ID_valid;
   logic             ID_ready;
   logic [PC_W-1:0]  ID_pc_plus_4;
   logic [INS_W-1:0] ID_ins;
   logic             flush;
`ifdef IF_ID_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [PC_W+INS_W-1:0] exp_q[$];
   bit                    sb_en     = 1'b0;
   bit                    hold_prev = 1'b0;
   logic [PC_W+INS_W-1:0] prev_out;

   if_id_skid_reg #(
      .INS_W  (INS_W),
      .PC_W   (PC_W),
      .NOP_INS(NOP),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .IF_valid    (IF_valid),
      .IF_ready    (IF_ready),
      .IF_pc_plus_4(IF_pc_plus_4),
      .IF_ins      (IF_ins),
      .ID_valid    (ID_valid),
      .ID_ready    (ID_ready),
      .ID_pc_plus_4(ID_pc_plus_4),
      .ID_ins      (ID_ins),
      .flush       (flush)
`ifdef IF_ID_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: samples on the falling edge, between driver updates.
   always @(negedge clk) begin
      logic [PC_W+INS_W-1:0] exp_e;
      if (sb_en && rst_n) begin
         n_checks++;
         if (ID_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_id_valid: got %b expected %b", ID_valid, exp_q.size() != 0);
         end
         n_checks++;
         if (IF_ready !== (exp_q.size() < 2)) begin
            n_fail++;
            $display("FAIL sb_if_ready: got %b expected %b", IF_ready, exp_q.size() < 2);
         end
         if (ID_valid !== 1'b1) begin
            n_checks++;
            if ({ID_pc_plus_4, ID_ins} !== {{PC_W{1'b0}}, NOP}) begin
               n_fail++;
               $display("FAIL sb_idle_out: got %h/%h expected 0/%h", ID_pc_plus_4, ID_ins, NOP);
            end
         end
         if (hold_prev) begin
            n_checks++;
            if ({ID_pc_plus_4, ID_ins} !== prev_out) begin
               n_fail++;
               $display("FAIL sb_stable: got %h expected %h", {ID_pc_plus_4, ID_ins}, prev_out);
            end
         end
         if (ID_valid === 1'b1 && ID_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_order: got unexpected %h expected no entry", {ID_pc_plus_4, ID_ins});
            end else begin
               exp_e = exp_q.pop_front();
               if ({ID_pc_plus_4, ID_ins} !== exp_e) begin
                  n_fail++;
                  $display("FAIL sb_order: got %h expected %h", {ID_pc_plus_4, ID_ins}, exp_e);
               end
            end
         end
         if (flush === 1'b1) begin
            exp_q.delete();
         end else if (IF_valid === 1'b1 && IF_ready === 1'b1) begin
            exp_q.push_back({IF_pc_plus_4, IF_ins});
         end
         hold_prev = (ID_valid === 1'b1) && (ID_ready === 1'b0) && (flush === 1'b0);
         prev_out  = {ID_pc_plus_4, ID_ins};
      end else begin
         hold_prev = 1'b0;
      end
   end

   // Driver tasks
   task automatic drive(input logic ifv, input logic [PC_W-1:0] pc,
                        input logic [INS_W-1:0] ins, input logic idr, input logic fl);
      IF_valid     = ifv;
      IF_pc_plus_4 = pc;
      IF_ins       = ins;
      ID_ready     = idr;
      flush        = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sb_en = 1'b0;
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      exp_q.delete();
      sb_en = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", ID_valid); end
      n_checks++;
      if (ID_ins !== NOP) begin n_fail++; $display("FAIL reset_id_ins: got %h expected %h", ID_ins, NOP); end
      n_checks++;
      if (ID_pc_plus_4 !== '0) begin n_fail++; $display("FAIL reset_id_pc: got %h expected 0", ID_pc_plus_4); end
      n_checks++;
      if (IF_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %b expected 1", IF_ready); end
`ifdef IF_ID_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
   endtask

   task automatic test_stream();
      logic [PC_W-1:0] pc;
      for (int i = 0; i < 3; i++) begin
         pc = PC_W'(4 * (i + 1));
         drive(1'b1, pc, INS_W'(32'h100 + i), 1'b1, 1'b0);
         tick();
         n_checks++;
         if (ID_valid !== 1'b1 || ID_pc_plus_4 !== pc || ID_ins !== INS_W'(32'h100 + i)) begin
            n_fail++;
            $display("FAIL stream_out%0d: got %b/%h/%h expected 1/%h/%h", i, ID_valid,
                     ID_pc_plus_4, ID_ins, pc, INS_W'(32'h100 + i));
         end
         n_checks++;
         if (IF_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d: got %b expected 1", i, IF_ready); end
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", ID_valid); end
   endtask

   task automatic test_stall();
      localparam logic [INS_W-1:0] INS_A = 32'hAAAA_0001;
      localparam logic [INS_W-1:0] INS_B = 32'hBBBB_0002;
      do_reset();
      drive(1'b1, 32'd16, INS_A, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (ID_valid !== 1'b1 || ID_ins !== INS_A || IF_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_one: got %b/%h/%b expected 1/%h/1", ID_valid, ID_ins, IF_ready, INS_A);
      end
      drive(1'b1, 32'd20, INS_B, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (IF_ready !== 1'b0 || ID_ins !== INS_A) begin
         n_fail++;
         $display("FAIL stall_full: got ready %b ins %h expected 0/%h", IF_ready, ID_ins, INS_A);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (IF_ready !== 1'b0 || ID_ins !== INS_A || ID_pc_plus_4 !== 32'd16) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got ready %b ins %h pc %h expected 0/%h/10", i,
                     IF_ready, ID_ins, ID_pc_plus_4, INS_A);
         end
      end
`ifdef IF_ID_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 4'd4) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 4", stall_cnt); end
`endif
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (ID_valid !== 1'b1 || ID_ins !== INS_B || ID_pc_plus_4 !== 32'd20 || IF_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got %b/%h/%h/%b expected 1/%h/14/1", ID_valid, ID_ins,
                  ID_pc_plus_4, IF_ready, INS_B);
      end
      tick();
      n_checks++;
      if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b expected 0", ID_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 32'd24, 32'h0A0A_0A0A, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd28, 32'h0B0B_0B0B, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd32, 32'h0C0C_0C0C, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++;
      if (ID_valid !== 1'b0 || ID_ins !== NOP || IF_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_full: got %b/%h/%b expected 0/%h/1", ID_valid, ID_ins, IF_ready, NOP);
      end
      drive(1'b1, 32'd36, 32'h0D0D_0D0D, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd40, 32'h0C0C_0C0D, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (ID_valid !== 1'b0 || ID_ins !== NOP) begin
            n_fail++;
            $display("FAIL flush_drop%0d: got %b/%h expected 0/%h", i, ID_valid, ID_ins, NOP);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 32'd44, 32'h1111_0001, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd48, 32'h1111_0002, 1'b0, 1'b0);
      tick();
      #2;
      sb_en = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ID_valid !== 1'b0 || IF_ready !== 1'b1 || ID_ins !== NOP || ID_pc_plus_4 !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %b/%b/%h/%h expected 0/1/%h/0", ID_valid, IF_ready,
                  ID_ins, ID_pc_plus_4, NOP);
      end
`ifdef IF_ID_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== '0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d expected 0", stall_cnt); end
`endif
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      exp_q.delete();
      sb_en = 1'b1;
      drive(1'b1, 32'd52, 32'h2222_0001, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (ID_valid !== 1'b1 || ID_pc_plus_4 !== 32'd52) begin
         n_fail++;
         $display("FAIL first_accept: got %b/%h expected 1/34", ID_valid, ID_pc_plus_4);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
   endtask

`ifdef IF_ID_STALL_CNT_EN
   task automatic test_saturation();
      int exp_cnt;
      do_reset();
      drive(1'b1, 32'd56, 32'h3333_0001, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         exp_cnt = (i + 1 > 15) ? 15 : i + 1;
         n_checks++;
         if (stall_cnt !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL stall_sat%0d: got %0d expected %0d", i, stall_cnt, exp_cnt);
         end
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      tick();
   endtask
`endif

   task automatic test_random();
      logic [PC_W-1:0] pc;
      pc = 32'h0000_1000;
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 3) != 0, pc, INS_W'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 63) == 0);
         pc = pc + 32'd4;
         tick();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (exp_q.size() != 0 || ID_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL random_drain: got %0d pending, valid %b expected 0/0", exp_q.size(), ID_valid);
      end
   endtask

   // Test sequence and final report
   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_async_reset();
`ifdef IF_ID_STALL_CNT_EN
      test_saturation();
`endif
      test_random();
      sb_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
